zc_normalizer: RTL and testbench
================================

Name: zc_normalizer

Overview:
- Pipelined normalization stage that sits directly downstream of the ALU leading/trailing zero counter.
- Takes an operand together with its zero count and mode bit, and shifts out the counted zeros.
  - Leading mode: shift left, so the MSB is 1.
  - Trailing mode: shift right, so the LSB is 1.
- Delivers the normalized word, the applied shift amount and a zero flag to the consumer (FP normalize / bit-scan paths) over a valid/ready handshake.

Parameters:
- WIDTH, 32, operand width in bits; supported values are powers of two from 8 to 64.
- CW, 6, count width; must equal $clog2(WIDTH)+1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  stage can accept a word this cycle.
- in_data  input  WIDTH  operand that was fed to the zero counter.
- in_count  input  CW  zero count produced by the zero counter for in_data.
- in_dir  input  1  1 = leading (shift left), 0 = trailing (shift right); same encoding as the counter's leading_or_trailing.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  WIDTH  normalized operand.
- out_shift  output  CW  shift amount actually applied; saturates at WIDTH.
- out_zero  output  1  operand was all zeros.
- out_err  output  1  count/data mismatch flag; present only with ZC_NORM_CHECK_EN, otherwise tied 0.

Behaviour:
- Reset (async, rst_n low): both stage valid bits, out_valid, out_data, out_shift, out_zero and out_err go to 0. Any in-flight words are discarded. Outputs stay 0 until the first new transfer completes.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Pipeline: two register stages.
  - S1 captures in_data, in_dir and the saturated count: sat = (in_count >= WIDTH) ? WIDTH : in_count.
  - S2 registers the barrel-shift result and drives all out_* directly from flops.
- Latency: 2 cycles from input transfer to out_valid, with no stalls.
- Throughput: 1 word per cycle while out_ready is held high.
- Stall rules:
  - S2 loads when !s2_valid || out_ready.
  - S1 advances into S2 under the same condition.
  - in_ready = !s1_valid || (!s2_valid || out_ready). This is combinational from out_ready; no skid buffer is used.
  - While stalled, S1 and S2 hold their contents. out_* must not change while out_valid && !out_ready.
- Shift and flag rules:
  - sat == WIDTH: out_data = 0, out_zero = 1, out_shift = WIDTH.
  - Otherwise, out_data = in_data << sat when in_dir = 1, or in_data >> sat when in_dir = 0. out_zero = 0 and out_shift = sat.
  - No sticky or rounding output is needed; only counted zeros are shifted out.
- Simultaneous load and drain: when S2 drains and S1 refills in the same cycle, both happen and no bubble is inserted.
- Reset mid-operation: the pipeline empties immediately. in_ready is 1 on the first edge after rst_n deasserts.

Optional Feature:
- Macro: ZC_NORM_CHECK_EN.
- Defined:
  - S1 independently recomputes the leading or trailing zero count of the captured data.
  - S2 raises out_err = 1, registered alongside the result, when the recomputed count differs from sat.
  - The result is still produced using sat, not the recomputed value.
- Undefined: no checker logic is built and out_err is constant 0.

Test Plan:
- Zero operand: in_data = 0, in_count = 32, in_dir = 1, out_ready = 1 -> two cycles later out_valid = 1, out_data = 0, out_zero = 1, out_shift = 32.
- Leading normalize: in_data = 0x0200_0000, in_count = 6, in_dir = 1 -> out_data = 0x8000_0000, out_shift = 6, out_zero = 0.
- Trailing normalize: in_data = 0x0000_0200, in_count = 9, in_dir = 0 -> out_data = 0x0000_0001, out_shift = 9. Out-of-range input in_count = 45 on nonzero data -> out_shift = 32, out_data = 0.
- Backpressure:
  - Stream 4 words with out_ready low for 3 cycles -> in_ready drops once both stages are full and out_* stay stable.
  - After out_ready rises, all 4 words emerge in order with no loss or duplication, 1 per cycle.
- Reset mid-stream: assert rst_n low with 2 words in flight -> out_valid = 0 immediately. After release, the next input appears after 2 cycles and the stale words never appear.
- ZC_NORM_CHECK_EN defined: in_data = 0x0000_0001, in_count = 30, in_dir = 1 -> out_err = 1, out_data = 0x4000_0000. The same case with in_count = 31 gives out_err = 0.

Source files
------------

// File: rtl/zc_normalizer.sv
// Two-stage normalizer behind the zero counter: shifts out the counted zeros toward MSB or LSB.
// Optional count/data consistency checker is built when ZC_NORM_CHECK_EN is defined.
module zc_normalizer #(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CW-1:0]    in_count,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_shift,
    output logic             out_zero,
    output logic             out_err
);

    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

`ifdef ZC_NORM_CHECK_EN
    // Counts zeros from the MSB (dir=1) or LSB (dir=0); all-zero data yields WIDTH.
    function automatic logic [CW-1:0] count_zeros(input logic [WIDTH-1:0] d, input logic dir);
        logic [CW-1:0] n;
        logic          found;
        n     = '0;
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!found) begin
                if (dir ? d[WIDTH-1-i] : d[i]) found = 1'b1;
                else                           n = n + 1'b1;
            end
        end
        return n;
    endfunction
`endif

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;
    logic             s1_dir_q, s1_dir_d;
    logic [CW-1:0]    s1_sat_q, s1_sat_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CW-1:0]    out_shift_q, out_shift_d;
    logic             out_zero_q, out_zero_d;
    logic             out_err_q, out_err_d;

    logic             s2_load;
    logic             in_ready_c;
    logic             in_fire;
    logic [CW-1:0]    in_sat;
    logic [WIDTH-1:0] shifted;
    logic             s1_err;

    // Stall control is purely combinational from out_ready; there is no skid buffer.
    always_comb begin
        s2_load    = !out_valid_q || out_ready;
        in_ready_c = !s1_valid_q || s2_load;
        in_fire    = in_valid && in_ready_c;
        in_sat     = (in_count >= WIDTH_C) ? WIDTH_C : in_count;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_dir_d   = s1_dir_q;
        s1_sat_d   = s1_sat_q;
        if (in_ready_c) s1_valid_d = in_valid;
        if (in_fire) begin
            s1_data_d = in_data;
            s1_dir_d  = in_dir;
            s1_sat_d  = in_sat;
        end
    end

    always_comb begin
        shifted = '0;
        if (s1_sat_q != WIDTH_C) begin
            shifted = s1_dir_q ? (s1_data_q << s1_sat_q) : (s1_data_q >> s1_sat_q);
        end
`ifdef ZC_NORM_CHECK_EN
        s1_err = (count_zeros(s1_data_q, s1_dir_q) != s1_sat_q);
`else
        s1_err = 1'b0;
`endif
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_shift_d = out_shift_q;
        out_zero_d  = out_zero_q;
        out_err_d   = out_err_q;
        if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d  = shifted;
                out_shift_d = s1_sat_q;
                out_zero_d  = (s1_sat_q == WIDTH_C);
                out_err_d   = s1_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_dir_q    <= 1'b0;
            s1_sat_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_shift_q <= '0;
            out_zero_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_dir_q    <= s1_dir_d;
            s1_sat_q    <= s1_sat_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_shift_q <= out_shift_d;
            out_zero_q  <= out_zero_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_shift = out_shift_q;
    assign out_zero  = out_zero_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_zc_normalizer.sv
// Bench for zc_normalizer: directed vectors, backpressure, reset mid-stream and random traffic
// against a queue-based reference model.
module tb_zc_normalizer;

    localparam int WIDTH = 32;
    localparam int CW    = 6;
    localparam int EW    = WIDTH + CW + 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [CW-1:0]    in_count;
    logic             in_dir;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    out_shift;
    logic             out_zero;
    logic             out_err;

    zc_normalizer #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_count(in_count), .in_dir(in_dir),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_shift(out_shift), .out_zero(out_zero), .out_err(out_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // expected entries: {err, zero, shift, data}
    logic [EW-1:0]    exp_q[$];
    logic [EW-1:0]    exp_e;
    logic             got_in, got_out;
    logic             obs_in_ready, obs_out_valid;
    logic [WIDTH-1:0] obs_data;
    logic [CW-1:0]    obs_shift;
    logic             obs_zero, obs_err;

    // Reference: shift by power-of-two multiply/divide; recount by scanning for the first one.
    function automatic logic [EW-1:0] ref_result(input logic [WIDTH-1:0] d, input int cnt,
                                                 input logic dir);
        int            sat;
        logic [63:0]   p, dd;
        logic [WIDTH-1:0] r;
        logic          z, e;
        sat = (cnt >= WIDTH) ? WIDTH : cnt;
        dd  = 64'(d);
        p   = 64'd1 << sat;
        if (sat == WIDTH) begin
            r = '0;
            z = 1'b1;
        end else begin
            z = 1'b0;
            if (dir) begin
                dd = dd * p;
                r  = dd[WIDTH-1:0];
            end else begin
                dd = dd / p;
                r  = dd[WIDTH-1:0];
            end
        end
        e = 1'b0;
`ifdef ZC_NORM_CHECK_EN
        begin
            int rc;
            rc = WIDTH;
            if (dir) begin
                for (int i = WIDTH - 1; i >= 0; i--) if (d[i]) begin rc = WIDTH - 1 - i; break; end
            end else begin
                for (int i = 0; i < WIDTH; i++) if (d[i]) begin rc = i; break; end
            end
            e = (rc != sat);
        end
`endif
        return {e, z, CW'(sat), r};
    endfunction

    task automatic drive_cycle(input logic v, input logic [WIDTH-1:0] d, input logic [CW-1:0] c,
                               input logic dir, input logic ordy);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_count  = c;
        in_dir    = dir;
        out_ready = ordy;
        #1;
        obs_in_ready  = in_ready;
        obs_out_valid = out_valid;
        obs_data      = out_data;
        obs_shift     = out_shift;
        obs_zero      = out_zero;
        obs_err       = out_err;
        got_in  = v && in_ready;
        got_out = out_valid && ordy;
        if (got_in) exp_q.push_back(ref_result(d, int'(c), dir));
    endtask

    task automatic idle(input logic ordy);
        drive_cycle(1'b0, '0, '0, 1'b0, ordy);
    endtask

    // Random operand with a known zero count in the requested direction.
    task automatic rand_word(output logic [WIDTH-1:0] d, output logic [CW-1:0] c, output logic dir);
        int z;
        dir = 1'($urandom_range(0, 1));
        z   = int'($urandom_range(0, WIDTH - 1));
        d   = $urandom;
        d   = dir ? ((d | 32'h8000_0000) >> z) : ((d | 32'h1) << z);
        c   = CW'(z);
        case ($urandom_range(0, 9))
            0: begin d = '0; c = CW'(WIDTH); end
            1: c = CW'($urandom_range(0, 63));
            default: ;
        endcase
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_count = '0; in_dir = 1'b0; out_ready = 1'b1;
        #12;
        n_checks++;
        if ({out_valid, out_data, out_shift, out_zero, out_err} !== '0)
            $display("FAIL reset_outputs: got v=%b d=%h s=%0d z=%b e=%b, want all 0",
                     out_valid, out_data, out_shift, out_zero, out_err);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);
        n_checks++;
        if (obs_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", obs_in_ready);
        else n_pass++;
    endtask

    task automatic test_directed;
        logic [WIDTH-1:0] v_data[7]  = '{32'h0, 32'h0200_0000, 32'h0000_0200, 32'h0000_1234,
                                         32'h8000_0001, 32'h8000_0000, 32'h0000_0001};
        logic [CW-1:0]    v_cnt[7]   = '{6'd32, 6'd6, 6'd9, 6'd45, 6'd0, 6'd31, 6'd32};
        logic             v_dir[7]   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [WIDTH-1:0] e_data[7]  = '{32'h0, 32'h8000_0000, 32'h0000_0001, 32'h0,
                                         32'h8000_0001, 32'h0000_0001, 32'h0};
        logic [CW-1:0]    e_shift[7] = '{6'd32, 6'd6, 6'd9, 6'd32, 6'd0, 6'd31, 6'd32};
        logic             e_zero[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 7; k++) begin
            drive_cycle(1'b1, v_data[k], v_cnt[k], v_dir[k], 1'b1);
            n_checks++;
            if (!got_in) $display("FAIL dir_accept[%0d]: in_ready=%b want 1", k, obs_in_ready);
            else n_pass++;
            idle(1'b1);
            n_checks++;
            if (obs_out_valid !== 1'b0) $display("FAIL dir_latency1[%0d]: out_valid=%b want 0", k, obs_out_valid);
            else n_pass++;
            idle(1'b1);
            n_checks++;
            if (obs_out_valid !== 1'b1 || obs_data !== e_data[k] || obs_shift !== e_shift[k] ||
                obs_zero !== e_zero[k])
                $display("FAIL dir_vec[%0d]: got v=%b d=%h s=%0d z=%b, want v=1 d=%h s=%0d z=%b",
                         k, obs_out_valid, obs_data, obs_shift, obs_zero, e_data[k], e_shift[k], e_zero[k]);
            else n_pass++;
            n_checks++;
            exp_e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            if ({obs_err, obs_zero, obs_shift, obs_data} !== exp_e)
                $display("FAIL dir_model[%0d]: got %h want %h", k, {obs_err, obs_zero, obs_shift, obs_data}, exp_e);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        logic [WIDTH-1:0] d;
        logic [CW-1:0]    c;
        logic             dir;
        int               outs = 0;
        int               accepted = 0;
        for (int k = 0; k < 16; k++) begin
            rand_word(d, c, dir);
            drive_cycle(1'b1, d, c, dir, 1'b1);
            if (got_in) accepted++;
            if (k >= 2) begin
                n_checks++;
                if (!got_out) $display("FAIL b2b_bubble[%0d]: out_valid=%b want 1", k, obs_out_valid);
                else n_pass++;
            end
            if (got_out) begin
                outs++;
                n_checks++;
                exp_e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                if ({obs_err, obs_zero, obs_shift, obs_data} !== exp_e)
                    $display("FAIL b2b_data[%0d]: got %h want %h", k, {obs_err, obs_zero, obs_shift, obs_data}, exp_e);
                else n_pass++;
            end
        end
        for (int k = 0; k < 6 && exp_q.size() != 0; k++) begin
            idle(1'b1);
            if (got_out) begin
                outs++;
                n_checks++;
                exp_e = exp_q.pop_front();
                if ({obs_err, obs_zero, obs_shift, obs_data} !== exp_e)
                    $display("FAIL b2b_drain: got %h want %h", {obs_err, obs_zero, obs_shift, obs_data}, exp_e);
                else n_pass++;
            end
        end
        n_checks++;
        if (accepted != 16 || outs != 16)
            $display("FAIL b2b_count: accepted=%0d outputs=%0d want 16/16", accepted, outs);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        logic [WIDTH-1:0] wd[4];
        logic [CW-1:0]    wc[4];
        logic             wdir[4];
        logic [EW:0]      snap;
        int               next = 0;
        int               outs = 0;
        for (int k = 0; k < 4; k++) rand_word(wd[k], wc[k], wdir[k]);
        snap = '0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (next < 4) drive_cycle(1'b1, wd[next], wc[next], wdir[next], cyc >= 4);
            else          idle(cyc >= 4);
            if (got_in) next++;
            if (cyc == 2 || cyc == 3) begin
                n_checks++;
                if (obs_in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b want 0", cyc, obs_in_ready);
                else n_pass++;
            end
            if (cyc == 2) snap = {obs_out_valid, obs_err, obs_zero, obs_shift, obs_data};
            if (cyc == 3) begin
                n_checks++;
                if ({obs_out_valid, obs_err, obs_zero, obs_shift, obs_data} !== snap || !obs_out_valid)
                    $display("FAIL bp_stable: got %h want %h with valid",
                             {obs_out_valid, obs_err, obs_zero, obs_shift, obs_data}, snap);
                else n_pass++;
            end
            if (cyc >= 4 && cyc <= 7) begin
                n_checks++;
                if (!got_out) $display("FAIL bp_rate[%0d]: out_valid=%b want 1", cyc, obs_out_valid);
                else n_pass++;
            end
            if (got_out) begin
                outs++;
                n_checks++;
                exp_e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                if ({obs_err, obs_zero, obs_shift, obs_data} !== exp_e)
                    $display("FAIL bp_order[%0d]: got %h want %h", cyc, {obs_err, obs_zero, obs_shift, obs_data}, exp_e);
                else n_pass++;
            end
        end
        n_checks++;
        if (outs != 4 || exp_q.size() != 0)
            $display("FAIL bp_count: outputs=%0d left=%0d want 4/0", outs, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_midstream;
        logic [WIDTH-1:0] d;
        logic [CW-1:0]    c;
        logic             dir;
        int               outs = 0;
        int               first_at = -1;
        for (int k = 0; k < 2; k++) begin
            rand_word(d, c, dir);
            drive_cycle(1'b1, d, c, dir, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0)
            $display("FAIL rst_mid_clear: out_valid=%b out_data=%h want 0/0", out_valid, out_data);
        else n_pass++;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(1'b1, 32'h0000_0F00, 6'd20, 1'b1, 1'b1);
        n_checks++;
        if (!got_in) $display("FAIL rst_mid_ready: in_ready=%b want 1", obs_in_ready);
        else n_pass++;
        for (int k = 1; k <= 6; k++) begin
            idle(1'b1);
            if (got_out) begin
                outs++;
                if (first_at < 0) first_at = k;
                n_checks++;
                exp_e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                if ({obs_err, obs_zero, obs_shift, obs_data} !== exp_e)
                    $display("FAIL rst_mid_data: got %h want %h", {obs_err, obs_zero, obs_shift, obs_data}, exp_e);
                else n_pass++;
            end
        end
        n_checks++;
        if (outs != 1 || first_at != 2)
            $display("FAIL rst_mid_stale: outputs=%0d first_at=%0d want 1/2", outs, first_at);
        else n_pass++;
    endtask

    task automatic test_random;
        logic [WIDTH-1:0] d;
        logic [CW-1:0]    c;
        logic             dir, v, r;
        logic             prev_stall = 1'b0;
        logic [EW:0]      prev_out = '0;
        int               errs = 0;
        for (int k = 0; k < 400 || (exp_q.size() != 0 && k < 440); k++) begin
            rand_word(d, c, dir);
            v = (k < 400) && ($urandom_range(0, 9) < 7);
            r = (k >= 400) || ($urandom_range(0, 9) < 6);
            drive_cycle(v, d, c, dir, r);
            if (prev_stall && {obs_out_valid, obs_err, obs_zero, obs_shift, obs_data} !== prev_out) begin
                errs++;
                $display("FAIL rand_stall_hold[%0d]: got %h want %h", k,
                         {obs_out_valid, obs_err, obs_zero, obs_shift, obs_data}, prev_out);
            end
            prev_stall = obs_out_valid && !r;
            prev_out   = {obs_out_valid, obs_err, obs_zero, obs_shift, obs_data};
            if (got_out) begin
                n_checks++;
                exp_e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                if ({obs_err, obs_zero, obs_shift, obs_data} !== exp_e)
                    $display("FAIL rand_data[%0d]: got %h want %h", k, {obs_err, obs_zero, obs_shift, obs_data}, exp_e);
                else n_pass++;
            end
        end
        n_checks++;
        if (errs != 0 || exp_q.size() != 0)
            $display("FAIL rand_final: hold_errors=%0d left=%0d want 0/0", errs, exp_q.size());
        else n_pass++;
    endtask

`ifdef ZC_NORM_CHECK_EN
    task automatic test_check_err;
        logic [CW-1:0] cnts[2] = '{6'd30, 6'd31};
        logic          e_err[2] = '{1'b1, 1'b0};
        logic [WIDTH-1:0] e_data[2] = '{32'h4000_0000, 32'h8000_0000};
        for (int k = 0; k < 2; k++) begin
            drive_cycle(1'b1, 32'h0000_0001, cnts[k], 1'b1, 1'b1);
            idle(1'b1);
            idle(1'b1);
            void'(exp_q.pop_front());
            n_checks++;
            if (obs_out_valid !== 1'b1 || obs_err !== e_err[k] || obs_data !== e_data[k])
                $display("FAIL chk_err[%0d]: got v=%b e=%b d=%h want v=1 e=%b d=%h",
                         k, obs_out_valid, obs_err, obs_data, e_err[k], e_data[k]);
            else n_pass++;
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_directed;
        test_back_to_back;
        test_backpressure;
        test_reset_midstream;
`ifdef ZC_NORM_CHECK_EN
        test_check_err;
`endif
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
